// File: rtl/ascon_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the Ascon permutation controller.
// Holds the sequencer state encoding and the standard round counts
// for p^a and p^b.
package ascon_pkg;

    // Number of rounds of the full (p^a) and reduced (p^b) permutation.
    localparam int unsigned ASCON_ROUNDS_A = 12;
    localparam int unsigned ASCON_ROUNDS_B = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

endpackage : ascon_pkg

// File: rtl/ascon_perm_ctrl.sv
`timescale 1ns/1ps
// ascon_perm_ctrl
// Sequencer for the Ascon permutation datapath. It accepts a start request,
// drives the state-mux select and state-register enable, and steps the
// round-constant index through p^a (indices 0..ROUNDS_A-1) or p^b
// (indices ROUNDS_A-ROUNDS_B..ROUNDS_A-1). Completion is a one-cycle done.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      permutation request, accepted only while ready=1
//   full       sampled with an accepted start: 1 = p^a, 0 = p^b
//   abort      cancels an operation in LOAD, ROUND or DONE
//   ready      idle and able to accept start
//   busy       operation in progress (LOAD or ROUND)
//   load_sel   state-mux select: 0 = external state, 1 = round output
//   state_en   state register write enable
//   round_idx  round-constant index for the current round
//   done       one-cycle pulse, state register holds the permuted result
//
// All outputs are registered; they are decoded from the next state and the
// next counter value so that they line up with the state they describe.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS_A  = ASCON_ROUNDS_A,
    parameter int unsigned ROUNDS_B  = ASCON_ROUNDS_B,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 full,
    input  logic                 abort,
    output logic                 ready,
    output logic                 busy,
    output logic                 load_sel,
    output logic                 state_en,
    output logic [CNT_WIDTH-1:0] round_idx,
    output logic                 done
);

    // Index of the last round, shared by both permutation variants.
    localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(ROUNDS_A - 1);
    // First round index of p^b: p^b uses the tail of the p^a constants.
    localparam logic [CNT_WIDTH-1:0] START_B   = CNT_WIDTH'(ROUNDS_A - ROUNDS_B);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    ctrl_state_t          state, state_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic                 mode, mode_nx;

    logic                 ready_d;
    logic                 busy_d;
    logic                 load_sel_d;
    logic                 state_en_d;
    logic [CNT_WIDTH-1:0] round_idx_d;
    logic                 done_d;

    // State, counter, mode flag and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= CNT_ZERO;
            mode      <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            load_sel  <= 1'b0;
            state_en  <= 1'b0;
            round_idx <= CNT_ZERO;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mode      <= mode_nx;
            ready     <= ready_d;
            busy      <= busy_d;
            load_sel  <= load_sel_d;
            state_en  <= state_en_d;
            round_idx <= round_idx_d;
            done      <= done_d;
        end
    end

    // Next state, counter and mode.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mode_nx  = mode;

        case (state)
            ST_IDLE: begin
                // abort in IDLE suppresses a simultaneous start
                if (start && !abort) begin
                    state_nx = ST_LOAD;
                    mode_nx  = full;
                end
            end
            ST_LOAD: begin
                state_nx = ST_ROUND;
                cnt_nx   = mode ? CNT_ZERO : START_B;
            end
            ST_ROUND: begin
                if (cnt == LAST_IDX) begin
                    state_nx = ST_DONE;
                    cnt_nx   = CNT_ZERO;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = CNT_ZERO;
            end
        endcase

        // abort overrides every other transition outside IDLE
        if (abort && (state != ST_IDLE)) begin
            state_nx = ST_IDLE;
            cnt_nx   = CNT_ZERO;
        end
    end

    // Moore output decode of the upcoming state.
    always_comb begin
        ready_d     = 1'b0;
        busy_d      = 1'b0;
        load_sel_d  = 1'b0;
        state_en_d  = 1'b0;
        round_idx_d = CNT_ZERO;
        done_d      = 1'b0;

        case (state_nx)
            ST_IDLE: begin
                ready_d = 1'b1;
            end
            ST_LOAD: begin
                busy_d     = 1'b1;
                state_en_d = 1'b1;
            end
            ST_ROUND: begin
                busy_d      = 1'b1;
                state_en_d  = 1'b1;
                load_sel_d  = 1'b1;
                round_idx_d = cnt_nx;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
            end
        endcase
    end

endmodule : ascon_perm_ctrl

// File: tb/tb_ascon_perm_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for ascon_perm_ctrl: directed steps with a queue of
// expected round indices filled at start and drained as rounds appear.
module tb_ascon_perm_ctrl;

    localparam int unsigned RA = 12;
    localparam int unsigned RB = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          full;
    logic          abort;
    logic          ready;
    logic          busy;
    logic          load_sel;
    logic          state_en;
    logic [CW-1:0] round_idx;
    logic          done;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    ascon_perm_ctrl #(
        .ROUNDS_A (RA),
        .ROUNDS_B (RB),
        .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .full     (full),
        .abort    (abort),
        .ready    (ready),
        .busy     (busy),
        .load_sel (load_sel),
        .state_en (state_en),
        .round_idx(round_idx),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".ready"},     32'(ready),     32'd1);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".done"},      32'(done),      32'd0);
        check({tag, ".state_en"},  32'(state_en),  32'd0);
        check({tag, ".load_sel"},  32'(load_sel),  32'd0);
        check({tag, ".round_idx"}, 32'(round_idx), 32'd0);
    endtask

    // One complete operation; with hold=1 start stays high afterwards.
    task automatic do_op(input logic f, input logic hold, input string tag);
        int n;
        int en_cnt;
        int lat;
        int exp_idx;
        logic got_done;
        n        = f ? int'(RA) : int'(RB);
        start    = 1'b1;
        full     = f;
        tick();
        if (!hold) start = 1'b0;
        full = ~f;
        for (int i = int'(RA) - n; i < int'(RA); i++) exp_q.push_back(i);
        check({tag, ".load_en"},  32'(state_en), 32'd1);
        check({tag, ".load_sel"}, 32'(load_sel), 32'd0);
        check({tag, ".load_busy"}, 32'(busy),    32'd1);
        check({tag, ".load_rdy"}, 32'(ready),    32'd0);
        en_cnt   = 1;
        lat      = 0;
        got_done = 1'b0;
        for (int k = 1; k <= 24 && !got_done; k++) begin
            tick();
            if (state_en && load_sel) begin
                exp_idx = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
                check({tag, ".round_idx"}, 32'(round_idx), 32'(exp_idx));
            end
            if (state_en) en_cnt++;
            if (done) begin
                got_done = 1'b1;
                lat      = k + 1;
                check({tag, ".done_busy"}, 32'(busy),     32'd0);
                check({tag, ".done_rdy"},  32'(ready),    32'd0);
                check({tag, ".done_en"},   32'(state_en), 32'd0);
            end
        end
        check({tag, ".done_lat"}, 32'(lat),          32'(n + 2));
        check({tag, ".en_cnt"},   32'(en_cnt),       32'(n + 1));
        check({tag, ".q_empty"},  32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
        check({tag, ".post_rdy"},  32'(ready), 32'd1);
        check({tag, ".post_done"}, 32'(done),  32'd0);
    endtask

    // Advance until round_idx reaches target in ROUND, bounded.
    task automatic wait_idx(input int target, input string tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            if (load_sel && (32'(round_idx) == 32'(target))) hit = 1'b1;
            else tick();
        end
        check({tag, ".reach_idx"}, 32'(hit), 32'd1);
    endtask

    initial begin
        int seen_done;
        rst   = 1'b1;
        start = 1'b0;
        full  = 1'b0;
        abort = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("idle");

        do_op(1'b1, 1'b0, "pa");
        do_op(1'b0, 1'b0, "pb");

        // start held high: back-to-back with one ready cycle between ops
        do_op(1'b1, 1'b1, "hold1");
        do_op(1'b1, 1'b1, "hold2");
        start = 1'b0;
        tick();
        tick();
        check_idle("hold_end");

        // abort mid-round: IDLE next cycle and no done afterwards
        start = 1'b1;
        full  = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(5, "abort");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_next");
        seen_done = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (done) seen_done++;
        end
        check("abort.no_done", 32'(seen_done), 32'd0);
        do_op(1'b1, 1'b0, "after_abort");

        // reset mid-round
        start = 1'b1;
        full  = 1'b0;
        tick();
        start = 1'b0;
        wait_idx(7, "rst_round");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_round");

        // reset while in DONE
        start = 1'b1;
        full  = 1'b0;
        tick();
        start = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 20 && seen_done == 0; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        check("rst_done.reach", 32'(seen_done), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_done");

        // start together with abort in IDLE: nothing begins
        tick();
        start = 1'b1;
        abort = 1'b1;
        full  = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort");
        tick();
        check_idle("start_abort2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_ascon_perm_ctrl
